// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel streaming window controller.
package sobel_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_e;

  // Row-major 3x3 window positions, pixel0 = top-left.
  localparam int unsigned WIN_P0 = 0;
  localparam int unsigned WIN_P1 = 1;
  localparam int unsigned WIN_P2 = 2;
  localparam int unsigned WIN_P3 = 3;
  localparam int unsigned WIN_P4 = 4;
  localparam int unsigned WIN_P5 = 5;
  localparam int unsigned WIN_P6 = 6;
  localparam int unsigned WIN_P7 = 7;
  localparam int unsigned WIN_P8 = 8;
  localparam int unsigned WIN_N  = 9;

endpackage

// File: rtl/sobel_conv.sv
// Combinational Sobel kernel: |Gx| + |Gy| over a 3x3 window, saturated to DATA_W bits.
module sobel_conv #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] pixel0,
  input  logic [DATA_W-1:0] pixel1,
  input  logic [DATA_W-1:0] pixel2,
  input  logic [DATA_W-1:0] pixel3,
  input  logic [DATA_W-1:0] pixel4,
  input  logic [DATA_W-1:0] pixel5,
  input  logic [DATA_W-1:0] pixel6,
  input  logic [DATA_W-1:0] pixel7,
  input  logic [DATA_W-1:0] pixel8,
  output logic [DATA_W-1:0] op_val
);
  localparam int unsigned SUM_W = DATA_W + 2;
  localparam int unsigned MAG_W = SUM_W + 1;

  logic [SUM_W-1:0] gx_p, gx_n, gy_p, gy_n, gx_abs, gy_abs;
  logic [MAG_W-1:0] mag;

  // Centre pixel carries zero weight in both kernels.
  logic unused_centre;
  assign unused_centre = ^pixel4;

  always_comb begin
    gx_p   = SUM_W'(pixel2) + (SUM_W'(pixel5) << 1) + SUM_W'(pixel8);
    gx_n   = SUM_W'(pixel0) + (SUM_W'(pixel3) << 1) + SUM_W'(pixel6);
    gy_p   = SUM_W'(pixel6) + (SUM_W'(pixel7) << 1) + SUM_W'(pixel8);
    gy_n   = SUM_W'(pixel0) + (SUM_W'(pixel1) << 1) + SUM_W'(pixel2);
    gx_abs = (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
    gy_abs = (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
    mag    = MAG_W'(gx_abs) + MAG_W'(gy_abs);
    op_val = (mag > MAG_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : DATA_W'(mag);
  end

endmodule

// File: rtl/sobel_line_buf.sv
// One image line of storage; single address port, read returns the pre-write contents.
module sobel_line_buf #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = $clog2(IMG_W)
) (
  input  logic              clk_i,
  input  logic [AW-1:0]     addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [IMG_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster-stream scheduler for sobel_conv: two line buffers, a 3x3 window and a
// registered edge-magnitude output stream with 1-cycle latency.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned DATA_W = sobel_pkg::DATA_W
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [DATA_W-1:0] iPIXEL,
  output logic              oDVAL,
  output logic              oSOF,
  output logic              oEOF,
  output logic [DATA_W-1:0] oPIXEL,
  output logic              oBUSY,
  output logic              oSYNC_ERR
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d, pos_c;
  logic [RW-1:0]     row_q, row_d, pos_r;
  logic [DATA_W-1:0] win_q [WIN_N];
  logic [DATA_W-1:0] win_d [WIN_N];
  logic              dval_q, sof_q, eof_q, err_q;
  logic [DATA_W-1:0] pix_q;

  logic              sof_in, accept, resync, last_px, win_ok;
  logic [DATA_W-1:0] lb_a_rd, lb_b_rd, conv_val;

  // An iSOF pixel always lands at (0,0), whatever the counters say.
  always_comb begin
    sof_in  = iDVAL & iSOF;
    accept  = iDVAL & ((state_q == RUN) | iSOF);
    resync  = sof_in & (state_q == RUN) & ~((col_q == '0) & (row_q == '0));
    pos_c   = sof_in ? '0 : col_q;
    pos_r   = sof_in ? '0 : row_q;
    last_px = (pos_c == CW'(IMG_W - 1)) & (pos_r == RW'(IMG_H - 1));
    win_ok  = (pos_r >= RW'(2)) & (pos_c >= CW'(2));
  end

  sobel_line_buf #(.IMG_W(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb_a (
    .clk_i   (iCLK),
    .addr_i  (pos_c),
    .we_i    (accept),
    .wdata_i (iPIXEL),
    .rdata_o (lb_a_rd)
  );

  sobel_line_buf #(.IMG_W(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb_b (
    .clk_i   (iCLK),
    .addr_i  (pos_c),
    .we_i    (accept),
    .wdata_i (lb_a_rd),
    .rdata_o (lb_b_rd)
  );

  // Window shift and raster position advance.
  always_comb begin
    win_d   = win_q;
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (accept) begin
      win_d[WIN_P0] = win_q[WIN_P1];
      win_d[WIN_P1] = win_q[WIN_P2];
      win_d[WIN_P2] = lb_b_rd;
      win_d[WIN_P3] = win_q[WIN_P4];
      win_d[WIN_P4] = win_q[WIN_P5];
      win_d[WIN_P5] = lb_a_rd;
      win_d[WIN_P6] = win_q[WIN_P7];
      win_d[WIN_P7] = win_q[WIN_P8];
      win_d[WIN_P8] = iPIXEL;
      if (last_px) begin
        col_d   = '0;
        row_d   = '0;
        state_d = WAIT_SOF;
      end else if (pos_c == CW'(IMG_W - 1)) begin
        col_d   = '0;
        row_d   = pos_r + RW'(1);
        state_d = RUN;
      end else begin
        col_d   = pos_c + CW'(1);
        row_d   = pos_r;
        state_d = RUN;
      end
    end
  end

  sobel_conv #(.DATA_W(DATA_W)) u_conv (
    .pixel0 (win_d[WIN_P0]),
    .pixel1 (win_d[WIN_P1]),
    .pixel2 (win_d[WIN_P2]),
    .pixel3 (win_d[WIN_P3]),
    .pixel4 (win_d[WIN_P4]),
    .pixel5 (win_d[WIN_P5]),
    .pixel6 (win_d[WIN_P6]),
    .pixel7 (win_d[WIN_P7]),
    .pixel8 (win_d[WIN_P8]),
    .op_val (conv_val)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= WAIT_SOF;
      col_q   <= '0;
      row_q   <= '0;
      for (int i = 0; i < int'(WIN_N); i++) win_q[i] <= '0;
      dval_q  <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      dval_q  <= accept;
      sof_q   <= sof_in;
      eof_q   <= accept & last_px;
      err_q   <= resync;
      // Border outputs are zero so stale columns from the previous line never leak.
      pix_q   <= (accept & win_ok) ? conv_val : '0;
    end
  end

  assign oDVAL     = dval_q;
  assign oSOF      = sof_q;
  assign oEOF      = eof_q;
  assign oPIXEL    = pix_q;
  assign oBUSY     = (state_q == RUN);
  assign oSYNC_ERR = err_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on a 4x4 image.
module tb_sobel_window_ctrl;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iDVAL = 1'b0, iSOF = 1'b0;
  logic [7:0] iPIXEL = '0;
  logic       oDVAL, oSOF, oEOF, oBUSY, oSYNC_ERR;
  logic [7:0] oPIXEL;

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iDVAL(iDVAL), .iSOF(iSOF), .iPIXEL(iPIXEL),
    .oDVAL(oDVAL), .oSOF(oSOF), .oEOF(oEOF), .oPIXEL(oPIXEL), .oBUSY(oBUSY),
    .oSYNC_ERR(oSYNC_ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       eof;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         total = 0, bad = 0;
  int         cyc = 0;
  int         exp_err_cyc = -1;
  logic       exp_busy = 1'b0;
  logic       mon_en = 1'b0;
  int         cap[64];
  int         cap_n = 0, err_seen = 0, eof_seen = 0;
  logic [7:0] img[H][W];
  logic       m_run = 1'b0;
  int         m_r = 0, m_c = 0;
  logic [7:0] frame[H][W];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_sobel(input int r, input int c);
    int kx[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int ky[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    int gx = 0, gy = 0, m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        gx += kx[i*3+j] * int'(img[r-2+i][c-2+j]);
        gy += ky[i*3+j] * int'(img[r-2+i][c-2+j]);
      end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  // Output comparator: pops the scoreboard on every oDVAL.
  always @(negedge clk) if (mon_en) begin
    exp_t e;
    if (oDVAL) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got oDVAL=1 pix=%0d at cyc %0d, required no output", oPIXEL, cyc);
      end else begin
        e = sb.pop_front();
        if (oPIXEL !== e.pix || oSOF !== e.sof || oEOF !== e.eof || cyc != e.due) begin
          bad++;
          $display("FAIL out_pixel: got pix=%0d sof=%b eof=%b cyc=%0d, required pix=%0d sof=%b eof=%b cyc=%0d",
                   oPIXEL, oSOF, oEOF, cyc, e.pix, e.sof, e.eof, e.due);
        end
        if (cap_n < 64) cap[cap_n] = int'(oPIXEL);
        cap_n++;
        if (oEOF) eof_seen++;
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      total++; bad++;
      $display("FAIL missing_out: got oDVAL=0 at cyc %0d, required pix=%0d", cyc, e.pix);
    end
    if (oSYNC_ERR) err_seen++;
    total++;
    if (oSYNC_ERR !== (cyc == exp_err_cyc)) begin
      bad++;
      $display("FAIL sync_err: got %b at cyc %0d, required %b", oSYNC_ERR, cyc, cyc == exp_err_cyc);
    end
    total++;
    if (oBUSY !== exp_busy) begin
      bad++;
      $display("FAIL busy: got %b at cyc %0d, required %b", oBUSY, cyc, exp_busy);
    end
  end

  // Drive one cycle of input and update the reference model.
  task automatic step(input logic dval, input logic sof, input logic [7:0] pix);
    exp_t e;
    iDVAL = dval; iSOF = sof; iPIXEL = pix;
    if (dval && (m_run || sof)) begin
      if (sof) begin
        if (m_run && !(m_r == 0 && m_c == 0)) exp_err_cyc = cyc + 1;
        m_r = 0; m_c = 0;
      end
      img[m_r][m_c] = pix;
      e.pix = (m_r >= 2 && m_c >= 2) ? 8'(ref_sobel(m_r, m_c)) : 8'd0;
      e.sof = (m_r == 0 && m_c == 0);
      e.eof = (m_r == H-1 && m_c == W-1);
      e.due = cyc + 1;
      sb.push_back(e);
      if (e.eof) begin
        m_run = 1'b0; m_r = 0; m_c = 0;
      end else begin
        m_run = 1'b1;
        if (m_c == W-1) begin m_c = 0; m_r++; end else m_c++;
      end
    end
    @(posedge clk); #1;
    exp_busy = m_run;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom_range(255, 0)));
  endtask

  task automatic send_frame(input logic gappy);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gappy) while ($urandom_range(1, 0) == 1) step(1'b0, 1'($urandom_range(1, 0)), 8'hAA);
        step(1'b1, (r == 0 && c == 0), frame[r][c]);
      end
  endtask

  task automatic drain;
    idle(3);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending outputs, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      iDVAL = i[0]; iSOF = i[1]; iPIXEL = 8'(i * 31);
      @(negedge clk);
      total++;
      if ({oDVAL, oSOF, oEOF, oBUSY, oSYNC_ERR, oPIXEL} !== 13'd0) begin
        bad++;
        $display("FAIL reset_outs: got %b, required 0", {oDVAL, oSOF, oEOF, oBUSY, oSYNC_ERR, oPIXEL});
      end
      @(posedge clk); #1;
    end
    iDVAL = 1'b0; iSOF = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(2);
  endtask

  task automatic test_uniform;
    foreach (frame[r, c]) frame[r][c] = 8'd62;
    cap_n = 0; eof_seen = 0;
    send_frame(1'b0);
    drain();
    total++;
    if (cap_n != 16 || eof_seen != 1) begin
      bad++;
      $display("FAIL uniform_count: got %0d outputs %0d eof, required 16 and 1", cap_n, eof_seen);
    end
    total++;
    if (oBUSY !== 1'b0) begin
      bad++;
      $display("FAIL uniform_busy: got %b, required 0", oBUSY);
    end
  endtask

  task automatic test_edge(input logic gappy);
    foreach (frame[r, c]) frame[r][c] = (r == 0) ? 8'd0 : 8'd62;
    cap_n = 0;
    send_frame(gappy);
    drain();
    total++;
    if (cap[10] != 248 || cap[11] != 248 || cap[14] != 0 || cap[9] != 0) begin
      bad++;
      $display("FAIL edge_vals: got %0d %0d %0d %0d, required 248 248 0 0", cap[10], cap[11], cap[14], cap[9]);
    end
  endtask

  task automatic test_back_to_back;
    foreach (frame[r, c]) frame[r][c] = ($urandom_range(1, 0) == 1) ? 8'd255 : 8'd0;
    cap_n = 0; eof_seen = 0;
    send_frame(1'b0);
    foreach (frame[r, c]) frame[r][c] = 8'($urandom_range(255, 0));
    send_frame(1'b0);
    drain();
    total++;
    if (cap_n != 32 || eof_seen != 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d outputs %0d eof, required 32 and 2", cap_n, eof_seen);
    end
  endtask

  task automatic test_resync;
    foreach (frame[r, c]) frame[r][c] = 8'($urandom_range(255, 0));
    cap_n = 0; eof_seen = 0; err_seen = 0;
    for (int i = 0; i < 9; i++) step(1'b1, (i == 0), frame[i / W][i % W]);
    foreach (frame[r, c]) frame[r][c] = 8'($urandom_range(200, 0));
    send_frame(1'b0);
    drain();
    total++;
    if (err_seen != 1 || eof_seen != 1 || cap_n != 25) begin
      bad++;
      $display("FAIL resync: got err=%0d eof=%0d outs=%0d, required 1 1 25", err_seen, eof_seen, cap_n);
    end
  endtask

  task automatic test_presof_reset;
    cap_n = 0; eof_seen = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i + 1));
    total++;
    if (cap_n != 0 || oBUSY !== 1'b0) begin
      bad++;
      $display("FAIL presof: got outs=%0d busy=%b, required 0 0", cap_n, oBUSY);
    end
    foreach (frame[r, c]) frame[r][c] = 8'($urandom_range(255, 0));
    for (int i = 0; i < 13; i++) step(1'b1, (i == 0), frame[i / W][i % W]);
    rst_n = 1'b0;
    #1;
    total++;
    if ({oDVAL, oSOF, oEOF, oBUSY, oPIXEL} !== 12'd0) begin
      bad++;
      $display("FAIL midreset: got %b, required 0", {oDVAL, oSOF, oEOF, oBUSY, oPIXEL});
    end
    sb.delete();
    m_run = 1'b0; m_r = 0; m_c = 0; exp_busy = 1'b0; exp_err_cyc = -1;
    iDVAL = 1'b0; iSOF = 1'b0;
    @(posedge clk); #1;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    cap_n = 0; eof_seen = 0;
    foreach (frame[r, c]) frame[r][c] = 8'($urandom_range(255, 0));
    send_frame(1'b1);
    drain();
    total++;
    if (cap_n != 16 || eof_seen != 1) begin
      bad++;
      $display("FAIL post_reset: got %0d outputs %0d eof, required 16 and 1", cap_n, eof_seen);
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_edge(1'b0);
    test_edge(1'b1);
    test_back_to_back();
    test_resync();
    test_presof_reset();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
